// File: rtl/eb_credit_tx.sv
// Credit-based link transmitter: 2-entry elastic input buffer feeding a non-stallable registered link.
// Optional credit-overflow detection is built when EB_CREDIT_TX_CHECK_EN is defined.
module eb_credit_tx #(
    parameter int DWIDTH  = 32,
    parameter int CREDITS = 4,
    parameter int CWIDTH  = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] t_data,
    input  logic              t_valid,
    output logic              t_ready,
    output logic [DWIDTH-1:0] i_data,
    output logic              i_valid,
    input  logic              i_credit,
    output logic [CWIDTH-1:0] credit_cnt,
    output logic              credit_err
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam logic [CWIDTH-1:0] CREDIT_MAX = CWIDTH'(CREDITS);

    occ_e              occ_q, occ_d;
    logic [DWIDTH-1:0] head_q, head_d;
    logic [DWIDTH-1:0] tail_q, tail_d;
    logic              t_ready_q, t_ready_d;
    logic [DWIDTH-1:0] i_data_q;
    logic              i_valid_q;
    logic [CWIDTH-1:0] credit_q, credit_d;
    logic [CWIDTH-1:0] credit_after_send;
    logic              accept;
    logic              send;
    logic              overflow;

    assign accept = t_valid & t_ready_q;
    assign send   = (occ_q != OCC_EMPTY) && (credit_q != '0);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (accept) begin
                    head_d = t_data;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                unique case ({accept, send})
                    2'b11: head_d = t_data;
                    2'b01: occ_d  = OCC_EMPTY;
                    2'b10: begin
                        tail_d = t_data;
                        occ_d  = OCC_FULL;
                    end
                    default: ;
                endcase
            end
            OCC_FULL: begin
                // t_ready is low here, so only a send can change the buffer.
                if (send) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
        t_ready_d = (occ_d != OCC_FULL);
    end

    // A returned credit that would exceed the far-end depth is dropped, not counted.
    always_comb begin
        credit_after_send = credit_q - CWIDTH'(send);
        overflow          = i_credit && (credit_after_send == CREDIT_MAX);
        credit_d          = credit_after_send;
        if (i_credit && !overflow) begin
            credit_d = credit_after_send + CWIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q     <= OCC_EMPTY;
            t_ready_q <= 1'b0;
            i_data_q  <= '0;
            i_valid_q <= 1'b0;
            credit_q  <= CREDIT_MAX;
        end else begin
            occ_q     <= occ_d;
            t_ready_q <= t_ready_d;
            i_valid_q <= send;
            credit_q  <= credit_d;
            if (send) begin
                i_data_q <= head_q;
            end
        end
    end

    // NOTE: payload slots are not reset; occupancy alone decides whether their contents are meaningful.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

`ifdef EB_CREDIT_TX_CHECK_EN
    logic credit_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_err_q <= 1'b0;
        end else if (overflow) begin
            credit_err_q <= 1'b1;
        end
    end

    assign credit_err = credit_err_q;
`else
    assign credit_err = 1'b0;
`endif

    assign t_ready    = t_ready_q;
    assign i_data     = i_data_q;
    assign i_valid    = i_valid_q;
    assign credit_cnt = credit_q;

endmodule
